// File: rtl/processor_pkg.sv
// processor_pkg: state encodings, opcodes, ALU selects and IR field positions for the control unit
package processor_pkg;
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;
  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int ADDR_HI = 11;
  localparam int ADDR_LO = 4;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 8;
  localparam int RB_HI   = 7;
  localparam int RB_LO   = 4;
  localparam int RD_HI   = 3;
  localparam int RD_LO   = 0;
endpackage

// File: rtl/processor_control_unit.sv
// processor_control_unit: Moore FSM sequencing the multi-cycle datapath from the IR contents
module processor_control_unit
  import processor_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int ADDR_W    = 8,
  parameter int REG_W     = 4,
  parameter int ALU_SEL_W = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [15:0]          IR,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic                 IR_ld,
  output logic [ADDR_W-1:0]    D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [REG_W-1:0]     RF_W_addr,
  output logic                 RF_W_en,
  output logic [REG_W-1:0]     RF_Ra_addr,
  output logic [REG_W-1:0]     RF_Rb_addr,
  output logic [ALU_SEL_W-1:0] ALU_s0,
  output logic [3:0]           State,
  output logic [3:0]           NextState
);
  state_t state, next_state;
  logic [OP_W-1:0] op;
  assign op = IR[OP_HI:OP_LO];
  assign State = state;
  assign NextState = next_state;
  always_ff @(posedge Clk)
    state <= Reset ? S_INIT : next_state;
  // Unlisted opcodes and illegal state encodings fall to NoOp and Init respectively
  always_comb begin
    next_state = S_INIT;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = op == OP_STORE ? S_STORE :
                             op == OP_LOAD  ? S_LOADA :
                             op == OP_ADD   ? S_ADD   :
                             op == OP_SUB   ? S_SUB   :
                             op == OP_HALT  ? S_HALT  : S_NOOP;
      S_LOADA:  next_state = S_LOADB;
      S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_INIT;
    endcase
  end
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_LOADA: begin
        D_addr = IR[ADDR_HI:ADDR_LO];
        RF_s   = 1'b1;
      end
      S_LOADB: begin
        D_addr    = IR[ADDR_HI:ADDR_LO];
        RF_s      = 1'b1;
        RF_W_addr = IR[RD_HI:RD_LO];
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = IR[ADDR_HI:ADDR_LO];
        RF_Ra_addr = IR[RD_HI:RD_LO];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[RA_HI:RA_LO];
        RF_Rb_addr = IR[RB_HI:RB_LO];
        ALU_s0     = state == S_ADD ? ALU_ADD : ALU_SUB;
        RF_W_addr  = IR[RD_HI:RD_LO];
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_processor_control_unit.sv
// tb_processor_control_unit: directed-vector self-checking bench for the control FSM
module tb_processor_control_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0] D_addr;
  logic [3:0] RF_W_addr, RF_Ra_addr, RF_Rb_addr, State, NextState;
  logic [2:0] ALU_s0;
  int checks = 0;
  int failures = 0;
  processor_control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .State(State), .NextState(NextState)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    check("excl_wr", {31'd0, D_wr & RF_W_en}, 32'd0);
    check("excl_pc", {31'd0, PC_clr & PC_up}, 32'd0);
  endtask
  // All strobes packed: PC_clr,PC_up,IR_ld,D_wr,RF_s,RF_W_en,D_addr,RF_W_addr,Ra,Rb,ALU_s0
  function automatic logic [31:0] strobes();
    return {3'd0, PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0};
  endfunction
  initial begin
    step();
    step();
    check("rst_state", State, 0);
    check("rst_next", NextState, 1);
    check("rst_strobes", strobes(), 32'h1000_0000);
    Reset = 1'b0;
    step();
    check("fetch_state", State, 1);
    check("fetch_strobes", strobes(), 32'h0C00_0000);
    IR = 16'h3125;
    step();
    check("add_dec", State, 2);
    check("add_dec_next", NextState, 7);
    check("add_dec_strobes", strobes(), 0);
    step();
    check("add_state", State, 7);
    check("add_strobes", strobes(), {3'd0, 6'b000001, 8'h00, 4'd5, 4'd1, 4'd2, 3'b001});
    check("add_next", NextState, 1);
    step();
    check("add_ret", State, 1);
    IR = 16'h21B3;
    step();
    check("ld_dec_next", NextState, 4);
    step();
    check("lda_state", State, 4);
    check("lda_strobes", strobes(), {3'd0, 6'b000010, 8'h1B, 4'd0, 4'd0, 4'd0, 3'b000});
    step();
    check("ldb_state", State, 5);
    check("ldb_strobes", strobes(), {3'd0, 6'b000011, 8'h1B, 4'd3, 4'd0, 4'd0, 3'b000});
    step();
    check("ld_ret", State, 1);
    IR = 16'h1A07;
    step();
    step();
    check("st_state", State, 6);
    check("st_strobes", strobes(), {3'd0, 6'b000100, 8'hA0, 4'd0, 4'd7, 4'd0, 3'b000});
    step();
    check("st_ret", State, 1);
    IR = 16'h4C9E;
    step();
    step();
    check("sub_state", State, 8);
    check("sub_strobes", strobes(), {3'd0, 6'b000001, 8'h00, 4'hE, 4'hC, 4'h9, 3'b010});
    step();
    IR = 16'hF000;
    step();
    check("nop_dec_next", NextState, 3);
    step();
    check("nop_state", State, 3);
    check("nop_strobes", strobes(), 0);
    step();
    check("nop_ret", State, 1);
    IR = 16'h5000;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check("halt_state", State, 9);
      check("halt_strobes", strobes(), 0);
      step();
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("halt_rst", State, 0);
    step();
    IR = 16'h21B3;
    step();
    step();
    check("abort_lda", State, 4);
    Reset = 1'b1;
    step();
    check("abort_state", State, 0);
    check("abort_wen", RF_W_en, 0);
    Reset = 1'b0;
    step();
    check("abort_fetch", State, 1);
    check("abort_wen2", RF_W_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
